// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF/EXE-MEM requesters, the arbiter and the downstream memory bridge.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [31:0] cpu_rdata;

    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    logic        err;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, cpu_rdata,
        output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, err
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, cpu_rdata,
        input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like port between instruction fetch and data load/store, tracking outstanding
// transactions in an in-order owner FIFO so each data_ok is routed back to the requester that issued it.
module mem_port_arbiter #(
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.slave  bus
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t                 state, state_nxt;
    logic [MAX_OUTST-1:0]   owner_q;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve_cnt;
    logic                   err_q;
    logic                   push, pop, head, slot_free, starve_hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    assign slot_free  = (count < CW'(MAX_OUTST));
    assign starve_hit = (starve_cnt == SW'(STARVE_LIM));
    assign push       = (state != IDLE) && bus.m_addr_ok;
    // A data_ok with an empty FIFO never pops, even if an ID is pushed in the same cycle.
    assign pop        = bus.m_data_ok && (count != '0);
    assign head       = owner_q[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (slot_free && (bus.inst_req || bus.data_req))
                    state_nxt = (bus.data_req && !(bus.inst_req && starve_hit)) ? GNT_D : GNT_I;
            end
            GNT_I, GNT_D: begin
                if (bus.m_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_req        = 1'b0;
        bus.m_wr         = 1'b0;
        bus.m_size       = 2'd2;
        bus.m_wstrb      = 4'h0;
        bus.m_addr       = bus.inst_addr;
        bus.m_wdata      = bus.data_wdata;
        bus.inst_addr_ok = 1'b0;
        bus.data_addr_ok = 1'b0;
        case (state)
            GNT_I: begin
                bus.m_req        = 1'b1;
                bus.inst_addr_ok = bus.m_addr_ok;
            end
            GNT_D: begin
                bus.m_req        = 1'b1;
                bus.m_wr         = bus.data_wr;
                bus.m_size       = bus.data_size;
                bus.m_wstrb      = bus.data_wstrb;
                bus.m_addr       = bus.data_addr;
                bus.data_addr_ok = bus.m_addr_ok;
            end
            default: ;
        endcase
    end

    assign bus.inst_data_ok = pop && !head;
    assign bus.data_data_ok = pop && head;
    assign bus.cpu_rdata    = bus.m_rdata;
    assign bus.err          = err_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (bus.m_data_ok && (count == '0)) err_q <= 1'b1;
        end
    end

    // Owner IDs are payload: only the pointers and count need a defined reset value.
    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr] <= (state == GNT_D);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                              starve_cnt <= '0;
        else if (!bus.inst_req)                   starve_cnt <= '0;
        else if (push && state == GNT_I)          starve_cnt <= '0;
        else if (push && state == GNT_D && !starve_hit) starve_cnt <= starve_cnt + SW'(1);
    end
endmodule
